// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: shared encodings and request legality check for the load/store unit
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  // Legal funct3 for the direction and naturally aligned for its access size.
  function automatic logic req_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    logic mis;
    legal = we ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
               : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return legal && !mis;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// lsu_load_align: picks the addressed byte/halfword of a read word and sign/zero extends it
module lsu_load_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  // Lane select, then extend with the sign bit only for the signed forms.
  always_comb begin
    b    = addr_lo[1] ? (addr_lo[0] ? rdata[31:24] : rdata[23:16])
                      : (addr_lo[0] ? rdata[15:8]  : rdata[7:0]);
    h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sx   = funct3 == F3_LB || funct3 == F3_LH;
    data = funct3[1:0] == 2'b00 ? {{24{sx & b[7]}}, b}
         : funct3[1:0] == 2'b01 ? {{16{sx & h[15]}}, h}
         : rdata;
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: one-at-a-time load/store sequencer over a req/gnt/rvalid data bus
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_addr_i,
  output logic        hold_flag_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [4:0]         rd_q;
  logic [31:0]        ld_data;
  logic               timeout;

  lsu_load_align u_align (
    .rdata   (mem_rdata_i),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (ld_data)
  );

  // Bus outputs are driven only in REQ; stores replicate data across all lanes.
  always_comb begin
    timeout     = cnt >= CNT_W'(TIMEOUT_CYCLES - 1);
    hold_flag_o = state != IDLE || req_valid_i;
    mem_req_o   = state == REQ;
    mem_we_o    = mem_req_o & we_q;
    mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : '0;
    mem_wstrb_o = !mem_we_o ? 4'b0000
                : f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                : f3_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0}
                : 4'b1111;
    mem_wdata_o = !mem_we_o ? 32'h0
                : f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
                : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}}
                : wdata_q;
  end

  // Transaction FSM; handshake wins over timeout when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_addr_o <= '0;
      wb_data_o    <= '0;
      err_o        <= 1'b0;
    end else begin
      err_o      <= 1'b0;
      wb_valid_o <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          we_q    <= req_we_i;
          f3_q    <= req_funct3_i;
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          rd_q    <= req_rd_addr_i;
          cnt     <= '0;
          if (req_ok(req_we_i, req_funct3_i, req_addr_i[1:0])) state <= REQ;
          else err_o <= 1'b1;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_gnt_i) state <= we_q ? IDLE : WAIT_R;
          else if (timeout) begin
            state <= IDLE;
            err_o <= 1'b1;
          end
        end
        WAIT_R: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid_i) begin
            wb_valid_o   <= 1'b1;
            wb_data_o    <= ld_data;
            wb_rd_addr_o <= rd_q;
            state        <= IDLE;
          end else if (timeout) begin
            state <= IDLE;
            err_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: vector table, random transactions and corner sequences for lsu_mem_stage
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [4:0]  req_rd_addr_i = '0;
  logic        hold_flag_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_rd_addr_i(req_rd_addr_i),
    .hold_flag_o  (hold_flag_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_addr_o (wb_rd_addr_o),
    .wb_data_o    (wb_data_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          gd;
    int          rv;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
    size = 1 << f3[1:0];
    return (int'(a[1:0]) % size) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    if (!we) return 4'h0;
    nbytes = 1 << f3[1:0];
    return 4'(((1 << nbytes) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic we, input logic [2:0] f3, input logic [31:0] wd);
    if (!we) return 32'h0;
    if (f3 == 3'd0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] v;
    logic [31:0] r;
    v = rdata >> (8 * a[1:0]);
    if (f3[1:0] == 2'd0) begin
      r = v & 32'hFF;
      if (f3 == 3'd0 && r >= 32'h80) r = r | 32'hFFFFFF00;
    end else if (f3[1:0] == 2'd1) begin
      r = v & 32'hFFFF;
      if (f3 == 3'd1 && r >= 32'h8000) r = r | 32'hFFFF0000;
    end else r = rdata;
    return r;
  endfunction

  task automatic do_txn(input vec_t v);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i = v.we;
    req_funct3_i = v.f3;
    req_addr_i = v.addr;
    req_wdata_i = v.wdata;
    req_rd_addr_i = v.rd;
    #1;
    chk("hold_accept", 32'(hold_flag_o), 1);
    chk("req_at_accept", 32'(mem_req_o), 0);
    @(negedge clk);
    req_valid_i = 1'b0;
    req_addr_i = $urandom;
    req_wdata_i = $urandom;
    req_funct3_i = 3'($urandom);
    if (v.exp_err) begin
      #1;
      chk("err_pulse", 32'(err_o), 1);
      chk("err_hold_drop", 32'(hold_flag_o), 0);
      chk("err_no_req", 32'(mem_req_o), 0);
      chk("err_no_wb", 32'(wb_valid_o), 0);
      @(negedge clk);
      #1 chk("err_single", 32'(err_o), 0);
      return;
    end
    for (int i = 0; i <= v.gd; i++) begin
      mem_gnt_i = (i == v.gd);
      mem_rvalid_i = 1'($urandom_range(0, 1));
      #1;
      chk("mem_req", 32'(mem_req_o), 1);
      chk("mem_addr", mem_addr_o, v.addr & ~32'h3);
      chk("mem_we", 32'(mem_we_o), 32'(v.we));
      chk("mem_wstrb", 32'(mem_wstrb_o), 32'(v.exp_strb));
      chk("mem_wdata", mem_wdata_o, v.exp_wdata);
      chk("hold_req", 32'(hold_flag_o), 1);
      chk("wb_in_req", 32'(wb_valid_o), 0);
      @(negedge clk);
    end
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    if (v.we) begin
      #1;
      chk("store_done_req", 32'(mem_req_o), 0);
      chk("store_done_hold", 32'(hold_flag_o), 0);
      chk("store_no_wb", 32'(wb_valid_o), 0);
      chk("store_no_err", 32'(err_o), 0);
      return;
    end
    for (int j = 0; j <= v.rv; j++) begin
      mem_rvalid_i = (j == v.rv);
      mem_rdata_i = (j == v.rv) ? v.rdata : $urandom;
      #1;
      chk("wait_req", 32'(mem_req_o), 0);
      chk("wait_hold", 32'(hold_flag_o), 1);
      chk("wait_wb", 32'(wb_valid_o), 0);
      @(negedge clk);
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i = $urandom;
    #1;
    chk("wb_valid", 32'(wb_valid_o), 1);
    chk("wb_data", wb_data_o, v.exp_data);
    chk("wb_rd", 32'(wb_rd_addr_o), 32'(v.rd));
    chk("wb_hold", 32'(hold_flag_o), 0);
    chk("wb_err", 32'(err_o), 0);
    @(negedge clk);
    #1 chk("wb_single", 32'(wb_valid_o), 0);
  endtask

  task automatic timeout_seq(input bit gnt_first);
    int req_cycles = 0;
    int wb_cnt = 0;
    int err_at = -1;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_funct3_i = 3'b010;
    req_addr_i = 32'h40;
    req_rd_addr_i = 5'd9;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      mem_gnt_i = gnt_first && k == 1;
      #1;
      if (mem_req_o) req_cycles++;
      if (wb_valid_o) wb_cnt++;
      if (err_o && err_at < 0) err_at = k;
      @(negedge clk);
    end
    mem_gnt_i = 1'b0;
    chk(gnt_first ? "to_wait_req_cycles" : "to_req_cycles", 32'(req_cycles), gnt_first ? 32'd1 : 32'd8);
    chk(gnt_first ? "to_wait_err_cycle" : "to_req_err_cycle", 32'(err_at), 32'd9);
    chk("to_no_wb", 32'(wb_cnt), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hold"}, 32'(hold_flag_o), 0);
    chk({tag, "_req"}, 32'(mem_req_o), 0);
    chk({tag, "_we"}, 32'(mem_we_o), 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_strb"}, 32'(mem_wstrb_o), 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_wbv"}, 32'(wb_valid_o), 0);
    chk({tag, "_wbrd"}, 32'(wb_rd_addr_o), 0);
    chk({tag, "_wbdata"}, wb_data_o, 0);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  initial begin
    vec_t rv;
    int wb_seen;
    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 5'd7,  0, 0, 32'hDEADBEEF, 4'b0000, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 5'd3,  1, 1, 32'hFFFFFF80, 4'b0000, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 5'd4,  0, 2, 32'h00000080, 4'b0000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 5'd5,  0, 0, 32'hFFFF8001, 4'b0000, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80010000, 5'd6,  1, 0, 32'h00008001, 4'b0000, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 5'd0,  2, 0, 32'h0000007F, 4'b0000, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 3'b000, 32'h205, 32'h000000AB, 32'h0,        5'd1,  3, 0, 32'h0,        4'b0010, 32'hABABABAB, 1'b0};
    vecs[7]  = '{1'b1, 3'b001, 32'h206, 32'h55661234, 32'h0,        5'd1,  0, 0, 32'h0,        4'b1100, 32'h12341234, 1'b0};
    vecs[8]  = '{1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        5'd1,  1, 0, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        5'd2,  0, 0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        5'd2,  0, 0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 3'b001, 32'h201, 32'h0,        32'h0,        5'd2,  0, 0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[12] = '{1'b1, 3'b100, 32'h200, 32'h0,        32'h0,        5'd2,  0, 0, 32'h0,        4'b0000, 32'h0,        1'b1};

    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) do_txn(vecs[i]);

    timeout_seq(1'b0);
    timeout_seq(1'b1);
    do_txn(vecs[0]);

    // reset while waiting for read data; the late rvalid must be ignored
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h80; req_rd_addr_i = 5'd11;
    @(negedge clk);
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    #1 chk("rst_pre_hold", 32'(hold_flag_o), 1);
    rst = 1'b1;
    #1 chk_all_zero("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    wb_seen = 0;
    for (int k = 0; k < 3; k++) begin
      #1 if (wb_valid_o) wb_seen++;
      @(negedge clk);
    end
    chk("rst_late_rvalid_wb", 32'(wb_seen), 0);
    chk("rst_idle_hold", 32'(hold_flag_o), 0);

    // reset while requesting drops the bus request immediately
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = 32'h44; req_wdata_i = 32'h1;
    @(negedge clk);
    req_valid_i = 1'b0;
    #1 chk("rst_req_pre", 32'(mem_req_o), 1);
    rst = 1'b1;
    #1 chk("rst_req_drop", 32'(mem_req_o), 0);
    chk("rst_req_strb", 32'(mem_wstrb_o), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 80; n++) begin
      rv.we = 1'($urandom_range(0, 1));
      rv.f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : (rv.we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      rv.addr = $urandom;
      if ($urandom_range(0, 3) != 0 && rv.f3[1:0] != 2'b00) rv.addr[1:0] = rv.f3[1:0] == 2'b01 ? {rv.addr[1], 1'b0} : 2'b00;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.rd = 5'($urandom);
      rv.gd = $urandom_range(0, 3);
      rv.rv = $urandom_range(0, 2);
      rv.exp_err = !m_legal(rv.we, rv.f3, rv.addr);
      rv.exp_strb = m_strb(rv.we, rv.f3, rv.addr);
      rv.exp_wdata = m_wdata(rv.we, rv.f3, rv.wdata);
      rv.exp_data = m_load(rv.f3, rv.addr, rv.rdata);
      do_txn(rv);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the execute stage. It takes one decoded load/store request per transaction and runs a req/gnt/rvalid handshake to the data memory bus.
- Returns aligned, sign- or zero-extended load data for register writeback.
- Asserts a hold flag into the pipeline control while a transaction is outstanding, so the IF/ID and ID/EX registers freeze.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ plus WAIT_R before the transaction is abandoned with err_o.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  load/store request from ex
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32I funct3 of the load/store
- req_addr_i  in  32  byte address (base+offset, computed in ex)
- req_wdata_i  in  32  store data (rs2)
- req_rd_addr_i  in  5  load destination register
- hold_flag_o  out  1  stall request to ctrl
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write enable
- mem_addr_o  out  32  word-aligned bus address
- mem_wstrb_o  out  4  byte write strobes
- mem_wdata_o  out  32  lane-positioned write data
- mem_gnt_i  in  1  bus grant
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data
- wb_valid_o  out  1  one-cycle writeback pulse
- wb_rd_addr_o  out  5  writeback register
- wb_data_o  out  32  extended load data
- err_o  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:

Reset and acceptance:
- Reset values: all outputs are 0, state is IDLE, counter is 0. Reset is asynchronous, so it drops mem_req_o mid-transaction. An mem_rvalid_i arriving after reset is ignored.
- States are IDLE, REQ and WAIT_R.
- IDLE: when req_valid_i=1, latch we, funct3, addr, wdata and rd.
- hold_flag_o = (state != IDLE) | (state == IDLE & req_valid_i). The stall is therefore visible in the acceptance cycle.

Request checks at acceptance:
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 is illegal.
- Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
- Illegal or misaligned: no bus activity, err_o pulses the next cycle, no wb_valid_o, state stays IDLE.
- Legal: move to REQ.

REQ state:
- mem_req_o=1; mem_addr_o = {addr[31:2], 2'b00}; mem_we_o = we.
- Write strobes:
  - SB: mem_wstrb_o = 4'b0001 << addr[1:0], byte replicated on all lanes.
  - SH: mem_wstrb_o = 4'b0011 << {addr[1], 1'b0}, halfword replicated.
  - SW: mem_wstrb_o = 4'b1111.
  - Loads: mem_wstrb_o = 0.
- Bus outputs are held stable until mem_gnt_i=1.
- On gnt: a store returns to IDLE; a load goes to WAIT_R.

WAIT_R state:
- mem_req_o=0; wait for mem_rvalid_i. The bus guarantees rvalid arrives no earlier than the cycle after gnt.
- rvalid sampled in REQ or IDLE is ignored.
- On rvalid:
  - Select byte (addr[1:0]) or halfword (addr[1]) from mem_rdata_i.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Register the result to wb_data_o with wb_rd_addr_o = rd and wb_valid_o=1 for exactly the next cycle, then return to IDLE.
- rd=0 still performs the access and pulses wb_valid_o; regs discards writes to x0.

Timeout:
- The counter clears on acceptance and increments each cycle in REQ or WAIT_R.
- When it reaches TIMEOUT_CYCLES: deassert mem_req_o, pulse err_o, no writeback, return to IDLE.

Latency and throughput:
- Minimum load latency: accept at T0, REQ with gnt at T1, rvalid at T2, wb_valid_o at T3.
- Minimum store latency: accept at T0, REQ with gnt at T1, IDLE at T2.
- At most one outstanding transaction. A new req_valid_i is accepted only in IDLE; upstream stays frozen by hold.

Decomposition:
- Shared package holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - load/store opcode constants (7'b0000011, 7'b0100011);
  - the state encoding localparams.
- One natural sub-module, lsu_load_align: a combinational lane select plus sign/zero extend (rdata, addr[1:0], funct3 -> data).

Test Plan:
1. LW at addr 0x100; gnt on the first REQ cycle; rvalid 1 cycle later with rdata 0xDEADBEEF -> mem_addr_o=0x100, wstrb=0, wb_valid_o pulses once with wb_data_o=0xDEADBEEF, rd echoed, hold_flag_o high T0..T2.
2. LB at 0x103 with rdata 0x80FF_0000, then LBU at the same address -> wb_data_o=0xFFFFFF80, then 0x00000080. LH at 0x102 with rdata 0x8001_0000 -> 0xFFFF8001.
3. SB at 0x205 with wdata 0x000000AB; gnt delayed 3 cycles -> mem_addr_o=0x204, wstrb=4'b0010, wdata=0xABABABAB held stable for 4 cycles, no wb_valid_o, back to IDLE after gnt.
4. LW at 0x102, and separately funct3=3'b011 -> no mem_req_o, err_o one-cycle pulse, hold_flag_o deasserts the next cycle.
5. Load with gnt never asserted and TIMEOUT_CYCLES=8 -> mem_req_o drops after 8 cycles, err_o pulses, no writeback, the next request is accepted normally.
6. rst asserted in WAIT_R, with rvalid arriving 2 cycles after reset is released -> all outputs immediately 0, no wb_valid_o, state IDLE.
